conv_sched: RTL
===============

CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameter DSIZE, 256, input image memory size in bytes; AW = clog2(DSIZE).
REQ-002 Parameter KSIZE, 3, maximum kernel width/height supported.
REQ-003 Parameter MAC_LAT, 2, cycles from tap acceptance with mac_last to result valid in the MAC datapath.
REQ-004 Ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin one convolution pass.
REQ-007 data_width, data_hight  in  8 each  image dimensions in pixels.
REQ-008 di_x_stop, di_y_stop  in  8 each  last legal window origin, x and y.
REQ-009 stride_x, stride_y  in  4 each  window step.
REQ-010 kernel_width, kernel_hight  in  4 each  active kernel dimensions.
REQ-011 rd_ready  in  1  datapath can accept a tap this cycle.
REQ-012 rd_valid  out  1  tap issued; rd_addr, k_idx, mac_clr, mac_last are valid.
REQ-013 rd_addr  out  AW  byte address of the input pixel.
REQ-014 k_idx  out  clog2(KSIZE*KSIZE)  kernel coefficient index, ky*kernel_width+kx.
REQ-015 mac_clr, mac_last  out  1 each  first/last tap of the current window.
REQ-016 wr_valid  out  1  one-cycle output-write strobe; wr_addr  out  AW  output index.
REQ-017 busy, done, err  out  1 each  pass active; one-cycle completion pulse; config error, sticky until next start.

Function
REQ-018 FSM states IDLE, RUN, DRAIN, DONE; IDLE->RUN on start with valid config.
REQ-019 Config captured on the start cycle; later input changes have no effect until the next start.
REQ-020 start while busy=1 ignored.
REQ-021 Invalid config (kernel dim 0 or >KSIZE, di_x_stop+kernel_width>data_width, di_y_stop+kernel_hight>data_hight, data_width*data_hight>DSIZE): IDLE->DONE, err=1, no rd_valid/wr_valid.
REQ-022 Stride value 0 treated as 1.
REQ-023 Loop order, outermost first: oy, ox, ky, kx; oy/ox step by stride from 0; last origin is the largest multiple of stride <= stop.
REQ-024 rd_addr = (oy+ky)*data_width + (ox+kx), computed at AW bits without truncation for valid configs.
REQ-025 rd_valid=1 throughout RUN; counters advance only on rd_valid & rd_ready; outputs hold while rd_ready=0.
REQ-026 mac_clr=1 on the kx=ky=0 tap; mac_last=1 on the kx=kernel_width-1, ky=kernel_hight-1 tap; both set for a 1x1 kernel.
REQ-027 wr_valid pulses exactly MAC_LAT cycles after each accepted mac_last tap; wr_addr starts at 0, +1 per window; pipeline is a MAC_LAT-deep shift register, independent of rd_ready.
REQ-028 After the final tap is accepted: RUN->DRAIN, rd_valid=0; DRAIN->DONE on the final wr_valid cycle.
REQ-029 DONE lasts one cycle: done=1, busy=0 on the next edge; DONE->IDLE. busy=1 in RUN and DRAIN only.
REQ-030 Total windows = (di_x_stop/stride_x+1)*(di_y_stop/stride_y+1); taps = windows*kernel_width*kernel_hight.

Reset
REQ-031 rst=1 forces IDLE and clears all counters and the MAC_LAT pipeline on the same edge.
REQ-032 Reset values: rd_valid, mac_clr, mac_last, wr_valid, busy, done, err = 0; rd_addr, k_idx, wr_addr = 0.
REQ-033 rst asserted mid-pass aborts the pass; no wr_valid/done follows; start on the first cycle after rst deasserts is accepted.

Structure
REQ-034 Shared package conv_pkg holds the state enum, AW/k_idx width functions and default parameter constants.
REQ-035 One sub-module conv_win_cnt: a generic wrap counter (limit, step, enable, wrap out), instantiated for kx, ky, ox, oy.

Verification
REQ-036 8x8 image, 3x3 kernel, stride 1, stops 5, rd_ready=1 -> 324 taps, 36 wr_valid (wr_addr 0..35), first rd_addr sequence 0,1,2,8,9,10,16,17,18, done once.
REQ-037 Same image, stride 2 -> 9 windows, origins x,y in {0,2,4}, window 1 first rd_addr=2, 81 taps.
REQ-038 rd_ready toggling 50% random -> identical address/k_idx sequence to REQ-036, 36 wr_valid, each MAC_LAT after its mac_last acceptance.
REQ-039 kernel_width=4 with KSIZE=3 -> no rd_valid, err=1, done pulse 1 cycle after start.
REQ-040 rst asserted at tap 100 of REQ-036 -> all outputs 0 next edge, no done; restart runs full 36-window pass.
REQ-041 1x1 kernel, stride 1, stops 7 -> 64 taps each with mac_clr=mac_last=1, rd_addr 0..63.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution address scheduler.
package conv_pkg;

  localparam int DEF_DSIZE   = 256;
  localparam int DEF_KSIZE   = 3;
  localparam int DEF_MAC_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_t;

  function automatic int conv_aw(input int dsize);
    return (dsize > 1) ? $clog2(dsize) : 1;
  endfunction

  function automatic int conv_kiw(input int ksize);
    return (ksize * ksize > 1) ? $clog2(ksize * ksize) : 1;
  endfunction

endpackage

// File: rtl/conv_win_cnt.sv
// Wrap counter: steps by 'step' while enabled and returns to 0 once the next
// step would pass 'limit'; 'wrap' marks the enabled cycle that returns to 0.
module conv_win_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  input  logic [W-1:0] step,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  logic [W:0] nxt;
  logic       last;

  // One extra bit so a large step near the top of the range cannot alias.
  assign nxt  = {1'b0, cnt} + {1'b0, step};
  assign last = nxt > {1'b0, limit};
  assign wrap = en & last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : nxt[W-1:0];
    end
  end

endmodule

// File: rtl/conv_sched.sv
// Convolution tap scheduler: walks window origins and kernel taps, issues pixel
// reads with MAC control, and strobes one output write per window after MAC_LAT.
module conv_sched
  import conv_pkg::*;
#(
  parameter  int DSIZE   = DEF_DSIZE,
  parameter  int KSIZE   = DEF_KSIZE,
  parameter  int MAC_LAT = DEF_MAC_LAT,
  localparam int AW      = conv_aw(DSIZE),
  localparam int KIW     = conv_kiw(KSIZE)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [7:0]     data_width,
  input  logic [7:0]     data_hight,
  input  logic [7:0]     di_x_stop,
  input  logic [7:0]     di_y_stop,
  input  logic [3:0]     stride_x,
  input  logic [3:0]     stride_y,
  input  logic [3:0]     kernel_width,
  input  logic [3:0]     kernel_hight,
  input  logic           rd_ready,
  output logic           rd_valid,
  output logic [AW-1:0]  rd_addr,
  output logic [KIW-1:0] k_idx,
  output logic           mac_clr,
  output logic           mac_last,
  output logic           wr_valid,
  output logic [AW-1:0]  wr_addr,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [1:0]     dbg_state
);

  // rd_valid/rd_ready: a tap transfers on any cycle where both are high; while
  // rd_valid is high and rd_ready low, rd_addr/k_idx/mac_clr/mac_last hold.

  conv_state_t state;

  logic [7:0]   cfg_dw, cfg_xstop, cfg_ystop, cfg_sx, cfg_sy;
  logic [7:0]   cfg_kw_m1, cfg_kh_m1;
  logic [3:0]   cfg_kw;
  logic [7:0]   cnt_kx, cnt_ky, cnt_ox, cnt_oy;
  logic         kx_wrap, ky_wrap, ox_wrap, oy_wrap;
  logic         start_acc, fire, final_tap, push, inflight, cfg_ok;
  logic         k_bad, fit_bad, area_bad;
  logic [MAC_LAT-1:0] pipe;
  logic [AW-1:0]      wr_cnt;
  logic [AW-1:0]      row, col, dw_aw;
  logic [2*AW-1:0]    prod;
  logic [7:0]         kval;

  assign start_acc = (state == ST_IDLE) && start;
  assign rd_valid  = (state == ST_RUN);
  assign fire      = rd_valid && rd_ready;
  assign final_tap = oy_wrap;
  assign push      = fire && mac_last;
  assign wr_valid  = pipe[MAC_LAT-1];
  assign wr_addr   = wr_cnt;
  assign dbg_state = state;

  assign k_bad    = (kernel_width == 4'd0) || (int'(kernel_width) > KSIZE) ||
                    (kernel_hight == 4'd0) || (int'(kernel_hight) > KSIZE);
  assign fit_bad  = ({1'b0, di_x_stop} + {5'b0, kernel_width} > {1'b0, data_width}) ||
                    ({1'b0, di_y_stop} + {5'b0, kernel_hight} > {1'b0, data_hight});
  assign area_bad = (int'(data_width) * int'(data_hight)) > DSIZE;
  assign cfg_ok   = !(k_bad || fit_bad || area_bad);

  conv_win_cnt #(.W(8)) u_kx (
    .clk(clk), .rst(rst), .clr(start_acc), .en(fire),
    .limit(cfg_kw_m1), .step(8'd1), .cnt(cnt_kx), .wrap(kx_wrap)
  );
  conv_win_cnt #(.W(8)) u_ky (
    .clk(clk), .rst(rst), .clr(start_acc), .en(kx_wrap),
    .limit(cfg_kh_m1), .step(8'd1), .cnt(cnt_ky), .wrap(ky_wrap)
  );
  conv_win_cnt #(.W(8)) u_ox (
    .clk(clk), .rst(rst), .clr(start_acc), .en(ky_wrap),
    .limit(cfg_xstop), .step(cfg_sx), .cnt(cnt_ox), .wrap(ox_wrap)
  );
  conv_win_cnt #(.W(8)) u_oy (
    .clk(clk), .rst(rst), .clr(start_acc), .en(ox_wrap),
    .limit(cfg_ystop), .step(cfg_sy), .cnt(cnt_oy), .wrap(oy_wrap)
  );

  // Valid configs keep the full address below DSIZE, so AW bits never truncate.
  assign row   = AW'(cnt_oy) + AW'(cnt_ky);
  assign col   = AW'(cnt_ox) + AW'(cnt_kx);
  assign dw_aw = AW'(cfg_dw);
  assign prod  = {{AW{1'b0}}, row} * {{AW{1'b0}}, dw_aw};
  assign kval  = cnt_ky * {4'b0, cfg_kw} + cnt_kx;

  assign rd_addr  = rd_valid ? (prod[AW-1:0] + col) : '0;
  assign k_idx    = rd_valid ? kval[KIW-1:0] : '0;
  assign mac_clr  = rd_valid && (cnt_kx == 8'd0) && (cnt_ky == 8'd0);
  assign mac_last = rd_valid && (cnt_kx == cfg_kw_m1) && (cnt_ky == cfg_kh_m1);

  always_comb begin
    inflight = 1'b0;
    for (int i = 0; i < MAC_LAT - 1; i++) inflight = inflight | pipe[i];
  end

  // MAC result pipeline; runs freely regardless of rd_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= push;
      for (int i = 1; i < MAC_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      wr_cnt    <= '0;
      cfg_dw    <= '0;
      cfg_xstop <= '0;
      cfg_ystop <= '0;
      cfg_sx    <= 8'd1;
      cfg_sy    <= 8'd1;
      cfg_kw    <= '0;
      cfg_kw_m1 <= '0;
      cfg_kh_m1 <= '0;
    end else begin
      done <= 1'b0;
      if (wr_valid) wr_cnt <= wr_cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cfg_dw    <= data_width;
            cfg_xstop <= di_x_stop;
            cfg_ystop <= di_y_stop;
            cfg_sx    <= (stride_x == 4'd0) ? 8'd1 : {4'b0, stride_x};
            cfg_sy    <= (stride_y == 4'd0) ? 8'd1 : {4'b0, stride_y};
            cfg_kw    <= kernel_width;
            cfg_kw_m1 <= {4'b0, kernel_width} - 8'd1;
            cfg_kh_m1 <= {4'b0, kernel_hight} - 8'd1;
            wr_cnt    <= '0;
            if (cfg_ok) begin
              state <= ST_RUN;
              busy  <= 1'b1;
              err   <= 1'b0;
            end else begin
              state <= ST_DONE;
              err   <= 1'b1;
              done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (final_tap) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Final write is the one with nothing younger left in the pipe.
          if (wr_valid && !inflight) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
